// File: rtl/stg4mo_hs_pkg.sv
// Shared definitions for the stage-4 memory-operation block: FSM states,
// op classes, default widths and the opcode values used for classification.
package stg4mo_hs_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_LD   = 2'd1;
    localparam logic [1:0] CLS_ST   = 2'd2;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_ADDR_W   = 24;
    localparam int DEF_OPC_W    = 8;
    localparam int DEF_TGT_GP_W = 4;
    localparam int DEF_TGT_SR_W = 2;

    localparam logic [7:0] OPC_ADD     = 8'h01;
    localparam logic [7:0] OPC_R_LD    = 8'h10;
    localparam logic [7:0] OPC_R_ST    = 8'h11;
    localparam logic [7:0] OPC_I_STi   = 8'h12;
    localparam logic [7:0] OPC_IS_STis = 8'h13;

endpackage

// File: rtl/stg4mo_hs_pmux.sv
// Memory port fan-out: drives one request onto the selected port (others 0)
// and picks the ack/rdata of the selected port.
// Ports: req/we/addr/wdata/sel in -> mem_req/mem_we/mem_addr/mem_wdata out;
//        mem_ack/mem_rdata in -> ack_sel/rdata_sel out.
module stg4mo_hs_pmux #(
    parameter int N_PORTS = 2,
    parameter int MP_W    = 1,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 24
) (
    input  logic                        req,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [MP_W-1:0]             sel,
    input  logic [N_PORTS-1:0]          mem_ack,
    input  logic [N_PORTS*DATA_W-1:0]   mem_rdata,
    output logic [N_PORTS-1:0]          mem_req,
    output logic [N_PORTS-1:0]          mem_we,
    output logic [N_PORTS*ADDR_W-1:0]   mem_addr,
    output logic [N_PORTS*DATA_W-1:0]   mem_wdata,
    output logic                        ack_sel,
    output logic [DATA_W-1:0]           rdata_sel
);

    logic [31:0] sel_i;

    assign sel_i = 32'(sel);

    always_comb begin
        mem_req   = '0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (sel_i == 32'(k)) begin
                mem_req[k]                   = req;
                mem_we[k]                    = req & we;
                mem_addr[k*ADDR_W +: ADDR_W] = req ? addr : '0;
                mem_wdata[k*DATA_W +: DATA_W] = (req & we) ? wdata : '0;
                ack_sel                      = mem_ack[k];
                rdata_sel                    = mem_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/stg4mo_hs.sv
// Stage-4 memory-operation block: forwards non-memory ops in one cycle,
// runs loads/stores over N_PORTS req/ack ports and stalls stages 1-3 meanwhile.
// Ports: iw_clk, iw_rst (async high), stage-3 fields iw_*, stage-5 fields ow_*,
//        ow_stall, per-port ow_mem_req/we/addr/wdata, iw_mem_ack/rdata, ow_fault.
// Optional macro STG4MO_HS_TIMEOUT_EN: abort an access after TIMEOUT wait cycles.
module stg4mo_hs
    import stg4mo_hs_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OPC_W    = DEF_OPC_W,
    parameter int TGT_GP_W = DEF_TGT_GP_W,
    parameter int TGT_SR_W = DEF_TGT_SR_W,
    parameter int N_PORTS  = 2,
    parameter int MP_W     = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst,
    input  logic                        iw_valid,
    output logic                        ow_stall,
    input  logic [ADDR_W-1:0]           iw_pc,
    output logic [ADDR_W-1:0]           ow_pc,
    input  logic [DATA_W-1:0]           iw_instr,
    output logic [DATA_W-1:0]           ow_instr,
    input  logic [OPC_W-1:0]            iw_opc,
    output logic [OPC_W-1:0]            ow_opc,
    input  logic [TGT_GP_W-1:0]         iw_tgt_gp,
    input  logic                        iw_tgt_gp_we,
    output logic [TGT_GP_W-1:0]         ow_tgt_gp,
    output logic                        ow_tgt_gp_we,
    input  logic [TGT_SR_W-1:0]         iw_tgt_sr,
    input  logic                        iw_tgt_sr_we,
    output logic [TGT_SR_W-1:0]         ow_tgt_sr,
    output logic                        ow_tgt_sr_we,
    input  logic [ADDR_W-1:0]           iw_addr,
    input  logic [MP_W-1:0]             iw_mem_mp,
    input  logic [DATA_W-1:0]           iw_result,
    output logic [N_PORTS-1:0]          ow_mem_req,
    output logic [N_PORTS-1:0]          ow_mem_we,
    output logic [N_PORTS*ADDR_W-1:0]   ow_mem_addr,
    output logic [N_PORTS*DATA_W-1:0]   ow_mem_wdata,
    input  logic [N_PORTS-1:0]          iw_mem_ack,
    input  logic [N_PORTS*DATA_W-1:0]   iw_mem_rdata,
    output logic                        ow_valid,
    output logic [DATA_W-1:0]           ow_result,
    output logic                        ow_fault
);

    state_t                state;
    logic [ADDR_W-1:0]     h_pc;
    logic [DATA_W-1:0]     h_instr;
    logic [OPC_W-1:0]      h_opc;
    logic [TGT_GP_W-1:0]   h_tgt_gp;
    logic                  h_tgt_gp_we;
    logic [TGT_SR_W-1:0]   h_tgt_sr;
    logic                  h_tgt_sr_we;
    logic [ADDR_W-1:0]     h_addr;
    logic [MP_W-1:0]       h_mp;
    logic [DATA_W-1:0]     h_result;
    logic [1:0]            h_cls;
    logic [1:0]            in_cls;
    logic                  mp_ok;
    logic                  ack_sel;
    logic [DATA_W-1:0]     rdata_sel;

    assign ow_stall = (state == S_REQ);
    assign mp_ok    = 32'(iw_mem_mp) < 32'(N_PORTS);

    always_comb begin
        in_cls = CLS_NONE;
        if (mp_ok) begin
            if (iw_opc == OPC_W'(OPC_R_LD)) begin
                in_cls = CLS_LD;
            end else if (iw_opc == OPC_W'(OPC_R_ST) ||
                         iw_opc == OPC_W'(OPC_I_STi) ||
                         iw_opc == OPC_W'(OPC_IS_STis)) begin
                in_cls = CLS_ST;
            end
        end
    end

    stg4mo_hs_pmux #(
        .N_PORTS (N_PORTS),
        .MP_W    (MP_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_pmux (
        .req       (state == S_REQ),
        .we        (h_cls == CLS_ST),
        .addr      (h_addr),
        .wdata     (h_result),
        .sel       (h_mp),
        .mem_ack   (iw_mem_ack),
        .mem_rdata (iw_mem_rdata),
        .mem_req   (ow_mem_req),
        .mem_we    (ow_mem_we),
        .mem_addr  (ow_mem_addr),
        .mem_wdata (ow_mem_wdata),
        .ack_sel   (ack_sel),
        .rdata_sel (rdata_sel)
    );

`ifdef STG4MO_HS_TIMEOUT_EN
    // Abort when this no-ack cycle would bring the count up to TIMEOUT.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;
`else
    assign ow_fault = 1'b0;
`endif

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state        <= S_IDLE;
            h_pc         <= '0;
            h_instr      <= '0;
            h_opc        <= '0;
            h_tgt_gp     <= '0;
            h_tgt_gp_we  <= 1'b0;
            h_tgt_sr     <= '0;
            h_tgt_sr_we  <= 1'b0;
            h_addr       <= '0;
            h_mp         <= '0;
            h_result     <= '0;
            h_cls        <= CLS_NONE;
            ow_pc        <= '0;
            ow_instr     <= '0;
            ow_opc       <= '0;
            ow_tgt_gp    <= '0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr    <= '0;
            ow_tgt_sr_we <= 1'b0;
            ow_valid     <= 1'b0;
            ow_result    <= '0;
`ifdef STG4MO_HS_TIMEOUT_EN
            wait_cnt     <= '0;
            ow_fault     <= 1'b0;
`endif
        end else begin
            ow_valid <= 1'b0;
`ifdef STG4MO_HS_TIMEOUT_EN
            ow_fault <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (iw_valid && in_cls == CLS_NONE) begin
                        ow_pc        <= iw_pc;
                        ow_instr     <= iw_instr;
                        ow_opc       <= iw_opc;
                        ow_tgt_gp    <= iw_tgt_gp;
                        ow_tgt_gp_we <= iw_tgt_gp_we;
                        ow_tgt_sr    <= iw_tgt_sr;
                        ow_tgt_sr_we <= iw_tgt_sr_we;
                        ow_result    <= iw_result;
                        ow_valid     <= 1'b1;
                    end else if (iw_valid) begin
                        h_pc        <= iw_pc;
                        h_instr     <= iw_instr;
                        h_opc       <= iw_opc;
                        h_tgt_gp    <= iw_tgt_gp;
                        h_tgt_gp_we <= iw_tgt_gp_we;
                        h_tgt_sr    <= iw_tgt_sr;
                        h_tgt_sr_we <= iw_tgt_sr_we;
                        h_addr      <= iw_addr;
                        h_mp        <= iw_mem_mp;
                        h_result    <= iw_result;
                        h_cls       <= in_cls;
                        state       <= S_REQ;
`ifdef STG4MO_HS_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (ack_sel) begin
                        ow_pc        <= h_pc;
                        ow_instr     <= h_instr;
                        ow_opc       <= h_opc;
                        ow_tgt_gp    <= h_tgt_gp;
                        ow_tgt_gp_we <= h_tgt_gp_we;
                        ow_tgt_sr    <= h_tgt_sr;
                        ow_tgt_sr_we <= h_tgt_sr_we;
                        ow_result    <= (h_cls == CLS_LD) ? rdata_sel : h_result;
                        ow_valid     <= 1'b1;
                        state        <= S_IDLE;
`ifdef STG4MO_HS_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LAST) begin
                        ow_pc        <= h_pc;
                        ow_instr     <= h_instr;
                        ow_opc       <= h_opc;
                        ow_tgt_gp    <= h_tgt_gp;
                        ow_tgt_gp_we <= 1'b0;
                        ow_tgt_sr    <= h_tgt_sr;
                        ow_tgt_sr_we <= 1'b0;
                        ow_result    <= '0;
                        ow_valid     <= 1'b1;
                        ow_fault     <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stg4mo_hs.sv
// Directed self-checking bench for stg4mo_hs (2 ports, 24-bit data/address).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_stg4mo_hs;
    import stg4mo_hs_pkg::*;

    localparam int DW = 24;
    localparam int AW = 24;
    localparam int NP = 2;

    logic          clk;
    logic          rst;
    logic          valid;
    logic          stall;
    logic [AW-1:0] pc, o_pc;
    logic [DW-1:0] instr, o_instr;
    logic [7:0]    opc, o_opc;
    logic [3:0]    gp, o_gp;
    logic          gp_we, o_gp_we;
    logic [1:0]    sr, o_sr;
    logic          sr_we, o_sr_we;
    logic [AW-1:0] addr;
    logic [0:0]    mp;
    logic [DW-1:0] result;
    logic [NP-1:0] mreq, mwe, mack;
    logic [NP*AW-1:0] maddr;
    logic [NP*DW-1:0] mwdata, mrdata;
    logic          o_valid;
    logic [DW-1:0] o_result;
    logic          o_fault;

    int n_assert;
    int n_fail;

    stg4mo_hs #(
        .N_PORTS (NP),
        .MP_W    (1),
        .TIMEOUT (4)
    ) dut (
        .iw_clk       (clk),
        .iw_rst       (rst),
        .iw_valid     (valid),
        .ow_stall     (stall),
        .iw_pc        (pc),
        .ow_pc        (o_pc),
        .iw_instr     (instr),
        .ow_instr     (o_instr),
        .iw_opc       (opc),
        .ow_opc       (o_opc),
        .iw_tgt_gp    (gp),
        .iw_tgt_gp_we (gp_we),
        .ow_tgt_gp    (o_gp),
        .ow_tgt_gp_we (o_gp_we),
        .iw_tgt_sr    (sr),
        .iw_tgt_sr_we (sr_we),
        .ow_tgt_sr    (o_sr),
        .ow_tgt_sr_we (o_sr_we),
        .iw_addr      (addr),
        .iw_mem_mp    (mp),
        .iw_result    (result),
        .ow_mem_req   (mreq),
        .ow_mem_we    (mwe),
        .ow_mem_addr  (maddr),
        .ow_mem_wdata (mwdata),
        .iw_mem_ack   (mack),
        .iw_mem_rdata (mrdata),
        .ow_valid     (o_valid),
        .ow_result    (o_result),
        .ow_fault     (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] op, input logic [0:0] port,
                           input logic [AW-1:0] a, input logic [DW-1:0] r);
        valid  = 1'b1;
        opc    = op;
        mp     = port;
        addr   = a;
        result = r;
        pc     = 24'h000100 + {16'h0, op};
        instr  = 24'hC00000 | {16'h0, op};
        gp     = 4'd5;
        gp_we  = 1'b1;
        sr     = 2'd2;
        sr_we  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        present(OPC_ADD, 1'b0, 24'h0, 24'h777777);
        tick();
        tick();
        n_assert++;
        if ({o_valid, stall, mreq, mwe, o_fault} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 0",
                     {o_valid, stall, mreq, mwe, o_fault});
        end
        n_assert++;
        if (o_result !== 24'h0 || o_pc !== 24'h0 || o_gp_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: result %h pc %h gp_we %b want 0",
                     o_result, o_pc, o_gp_we);
        end
        valid = 1'b0;
        rst   = 1'b0;
        tick();
    endtask

    task automatic test_nonmem();
        present(OPC_ADD, 1'b0, 24'h0, 24'h00ABCD);
        n_assert++;
        if (stall !== 1'b0 || mreq !== 2'b00) begin
            n_fail++;
            $display("FAIL nonmem_pre: stall %b req %b want 0 00", stall, mreq);
        end
        tick();
        valid = 1'b0;
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL nonmem_out: valid %b result %h want 1 00abcd",
                     o_valid, o_result);
        end
        n_assert++;
        if (stall !== 1'b0 || mreq !== 2'b00 || o_opc !== OPC_ADD ||
            o_gp !== 4'd5 || o_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmem_side: stall %b req %b opc %h gp %h fault %b",
                     stall, mreq, o_opc, o_gp, o_fault);
        end
        tick();
        n_assert++;
        if (o_valid !== 1'b0 || o_result !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL nonmem_idle: valid %b result %h want 0 00abcd",
                     o_valid, o_result);
        end
    endtask

    task automatic test_load();
        int req_cyc = 0;
        int bad = 0;
        present(OPC_R_LD, 1'b1, 24'h000040, 24'h0);
        mrdata = {24'h123456, 24'h999999};
        tick();
        valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (mreq === 2'b10) req_cyc++;
            if (stall !== 1'b1 || o_valid !== 1'b0 ||
                maddr[AW +: AW] !== 24'h000040 || maddr[0 +: AW] !== 24'h0 ||
                mwe !== 2'b00) bad++;
            if (c == 3) mack = 2'b10;
            tick();
        end
        mack = 2'b00;
        n_assert++;
        if (req_cyc != 4 || bad != 0) begin
            n_fail++;
            $display("FAIL load_wait: req cycles %0d bad %0d want 4 0",
                     req_cyc, bad);
        end
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h123456 || stall !== 1'b0 ||
            mreq !== 2'b00) begin
            n_fail++;
            $display("FAIL load_done: valid %b result %h stall %b req %b",
                     o_valid, o_result, stall, mreq);
        end
        n_assert++;
        if (o_opc !== OPC_R_LD || o_pc !== 24'h000110 || o_sr !== 2'd2 ||
            o_sr_we !== 1'b1) begin
            n_fail++;
            $display("FAIL load_fields: opc %h pc %h sr %h sr_we %b",
                     o_opc, o_pc, o_sr, o_sr_we);
        end
    endtask

    task automatic test_store();
        present(OPC_R_ST, 1'b0, 24'h000080, 24'h00BEEF);
        tick();
        valid = 1'b0;
        n_assert++;
        if (mreq !== 2'b01 || mwe !== 2'b01 || mwdata[0 +: DW] !== 24'h00BEEF ||
            maddr[0 +: AW] !== 24'h000080 || mwdata[DW +: DW] !== 24'h0) begin
            n_fail++;
            $display("FAIL store_req: req %b we %b wdata %h addr %h",
                     mreq, mwe, mwdata, maddr[0 +: AW]);
        end
        mack = 2'b01;
        tick();
        mack = 2'b00;
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h00BEEF || mreq !== 2'b00 ||
            stall !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done: valid %b result %h req %b stall %b",
                     o_valid, o_result, mreq, stall);
        end
        present(OPC_I_STi, 1'b1, 24'h000084, 24'h0000AA);
        tick();
        valid = 1'b0;
        n_assert++;
        if (mreq !== 2'b10 || mwe !== 2'b10 || mwdata[DW +: DW] !== 24'h0000AA) begin
            n_fail++;
            $display("FAIL sti_req: req %b we %b wdata %h", mreq, mwe, mwdata);
        end
        mack = 2'b10;
        tick();
        mack = 2'b00;
    endtask

    task automatic test_spurious();
        int bad = 0;
        valid = 1'b0;
        mack  = 2'b11;
        tick();
        mack = 2'b00;
        n_assert++;
        if (stall !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack: stall %b valid %b want 0 0", stall, o_valid);
        end
        present(OPC_R_LD, 1'b1, 24'h000050, 24'h0);
        mrdata = {24'hA5A5A5, 24'h111111};
        tick();
        valid = 1'b0;
        mack  = 2'b01;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (stall !== 1'b1 || o_valid !== 1'b0 || mreq !== 2'b10) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrong_port_ack: %0d bad cycles want 0", bad);
        end
        mack = 2'b10;
        tick();
        mack = 2'b00;
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'hA5A5A5) begin
            n_fail++;
            $display("FAIL spurious_done: valid %b result %h want 1 a5a5a5",
                     o_valid, o_result);
        end
    endtask

    task automatic test_reset_mid();
        present(OPC_R_LD, 1'b1, 24'h000060, 24'h0);
        mrdata = {24'h0C0FFE, 24'h0};
        tick();
        valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_assert++;
        if (mreq !== 2'b00 || stall !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: req %b stall %b valid %b want 0",
                     mreq, stall, o_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        present(OPC_R_LD, 1'b1, 24'h000064, 24'h0);
        tick();
        valid = 1'b0;
        mack  = 2'b10;
        tick();
        mack = 2'b00;
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h0C0FFE) begin
            n_fail++;
            $display("FAIL after_reset_load: valid %b result %h want 1 0c0ffe",
                     o_valid, o_result);
        end
    endtask

    task automatic test_back_to_back();
        present(OPC_ADD, 1'b0, 24'h0, 24'h000001);
        tick();
        present(OPC_ADD, 1'b1, 24'h0, 24'h000002);
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h000001) begin
            n_fail++;
            $display("FAIL b2b_first: valid %b result %h want 1 000001",
                     o_valid, o_result);
        end
        tick();
        // port 1 select is out of range for a 1-port view only; here it is
        // a plain ADD, so it must still forward in one cycle
        mp = 1'b0;
        present(OPC_R_ST, 1'b0, 24'h0000F0, 24'h000003);
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h000002) begin
            n_fail++;
            $display("FAIL b2b_second: valid %b result %h want 1 000002",
                     o_valid, o_result);
        end
        tick();
        valid = 1'b0;
        n_assert++;
        if (o_valid !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_bubble: valid %b stall %b want 0 1",
                     o_valid, stall);
        end
        mack = 2'b01;
        tick();
        mack = 2'b00;
        n_assert++;
        if (o_valid !== 1'b1 || o_result !== 24'h000003) begin
            n_fail++;
            $display("FAIL b2b_store: valid %b result %h want 1 000003",
                     o_valid, o_result);
        end
    endtask

`ifdef STG4MO_HS_TIMEOUT_EN
    task automatic test_timeout();
        int req_cyc = 0;
        int guard = 0;
        present(OPC_R_LD, 1'b0, 24'h000070, 24'h0);
        tick();
        valid = 1'b0;
        while (o_valid !== 1'b1 && guard < 20) begin
            if (mreq === 2'b01) req_cyc++;
            guard++;
            tick();
        end
        n_assert++;
        if (req_cyc != 4 || guard >= 20) begin
            n_fail++;
            $display("FAIL timeout_wait: req cycles %0d guard %0d want 4",
                     req_cyc, guard);
        end
        n_assert++;
        if (o_fault !== 1'b1 || o_result !== 24'h0 || o_gp_we !== 1'b0 ||
            o_sr_we !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_out: fault %b result %h gp_we %b sr_we %b",
                     o_fault, o_result, o_gp_we, o_sr_we);
        end
        tick();
        n_assert++;
        if (o_fault !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: fault %b valid %b want 0 0",
                     o_fault, o_valid);
        end
    endtask
`endif

    initial begin
        n_assert = 0;
        n_fail   = 0;
        valid  = 1'b0;
        mack   = '0;
        mrdata = '0;
        mp     = '0;
        addr   = '0;
        result = '0;
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
`ifdef STG4MO_HS_TIMEOUT_EN
        test_timeout();
`else
        n_assert++;
        if (o_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_tied: got %b want 0", o_fault);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
